pe_row_sched: RTL and testbench

Sequencer for one processing-element (PE) row of the convolution accelerator. Per output pixel it drives the PE through three phases: load ipsum, K multiply-accumulate cycles, then output psum. It also generates the matching ifmap/weight buffer read addresses. It stops issuing pixels when the downstream psum buffer has no free entry, using a credit scheme. It sits between the layer-level controller (start/config) and the PE row plus its SRAM buffers.

---
 rtl/pe_row_sched.sv | 180 ++++++++++++++++++
 tb/tb_pe_row_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_sched.sv
// pe_row_sched: PE row sequencer (load/MAC/drain per pixel)
// with ifmap/weight address generation and psum credit flow control.
module pe_row_sched #(
  parameter int ADDR_W  = 12,
  parameter int PIX_W   = 10,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        kernel_size,
  input  logic [PIX_W-1:0]  num_pix,
  input  logic [3:0]        stride,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic              credit_return,
  output logic              pe_en,
  output logic              ipsum_load,
  output logic              mac_valid,
  output logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              psum_capture,
  output logic [PIX_W-1:0]  out_pix,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  state_e            state_q, state_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        ksz_q, ksz_d;
  logic [PIX_W-1:0]  npix_q, npix_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [3:0]        stride_q, stride_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] pbase_q, pbase_d;
  logic [ADDR_W-1:0] ifa_q, ifa_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [3:0]        cred_q, cred_d;
  logic              err_q, err_d;
  logic              drain;
  logic              cred_ok;

  assign drain   = (state_q == S_DRAIN);
  assign cred_ok = (cred_d != 4'd0);

  // Credit: a drain consumes one entry, a return frees one (saturating).
  always_comb begin
    cred_d = cred_q;
    if (drain && !credit_return) begin
      cred_d = cred_q - 4'd1;
    end else if (!drain && credit_return
                 && cred_q != CRED_MAX) begin
      cred_d = cred_q + 4'd1;
    end
  end

  // Next-state, counters, config latch and address generation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    ksz_d    = ksz_q;
    npix_d   = npix_q;
    pix_d    = pix_q;
    stride_d = stride_q;
    wbase_d  = wbase_q;
    pbase_d  = pbase_q;
    ifa_d    = ifa_q;
    wa_d     = wa_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kernel_size == 8'd0 || num_pix == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d    = 1'b0;
            ksz_d    = kernel_size;
            npix_d   = num_pix;
            stride_d = stride;
            wbase_d  = w_base;
            pbase_d  = if_base;
            pix_d    = '0;
            k_d      = 8'd0;
            state_d  = cred_ok ? S_LOAD : S_WAIT;
          end
        end
      end
      S_LOAD: begin
        k_d     = 8'd0;
        ifa_d   = pbase_q;
        wa_d    = wbase_q;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == ksz_q - 8'd1) begin
          state_d = S_DRAIN;
        end else begin
          k_d   = k_q + 8'd1;
          ifa_d = ifa_q + ADDR_W'(1);
          wa_d  = wa_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (pix_q == npix_q - PIX_W'(1)) begin
          state_d = S_DONE;
        end else begin
          pix_d   = pix_q + PIX_W'(1);
          pbase_d = pbase_q + ADDR_W'(stride_q);
          state_d = cred_ok ? S_LOAD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cred_ok) state_d = S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and config registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      k_q      <= 8'd0;
      ksz_q    <= 8'd0;
      npix_q   <= '0;
      pix_q    <= '0;
      stride_q <= 4'd0;
      wbase_q  <= '0;
      pbase_q  <= '0;
      ifa_q    <= '0;
      wa_q     <= '0;
      cred_q   <= CRED_MAX;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ksz_q    <= ksz_d;
      npix_q   <= npix_d;
      pix_q    <= pix_d;
      stride_q <= stride_d;
      wbase_q  <= wbase_d;
      pbase_q  <= pbase_d;
      ifa_q    <= ifa_d;
      wa_q     <= wa_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
    end
  end

  assign pe_en        = (state_q == S_LOAD) || (state_q == S_MAC)
                        || drain;
  assign ipsum_load   = (state_q == S_LOAD);
  assign mac_valid    = (state_q == S_MAC);
  assign psum_capture = drain;
  assign out_pix      = drain ? pix_q : '0;
  assign if_addr      = ifa_q;
  assign w_addr       = wa_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign cfg_err      = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_pe_row_sched.sv
// tb_pe_row_sched: randomized + directed bench for pe_row_sched
// against a per-pixel phase reference model.
module tb_pe_row_sched;

  localparam int AW  = 12;
  localparam int PW  = 10;
  localparam int CR  = 4;
  localparam int TRN = 600;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    kernel_size;
  logic [PW-1:0] num_pix;
  logic [3:0]    stride;
  logic [AW-1:0] if_base;
  logic [AW-1:0] w_base;
  logic          credit_return;
  logic          pe_en;
  logic          ipsum_load;
  logic          mac_valid;
  logic [AW-1:0] if_addr;
  logic [AW-1:0] w_addr;
  logic          psum_capture;
  logic [PW-1:0] out_pix;
  logic          busy;
  logic          done;
  logic          cfg_err;

  pe_row_sched #(
    .ADDR_W (AW),
    .PIX_W  (PW),
    .CREDITS(CR)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .kernel_size  (kernel_size),
    .num_pix      (num_pix),
    .stride       (stride),
    .if_base      (if_base),
    .w_base       (w_base),
    .credit_return(credit_return),
    .pe_en        (pe_en),
    .ipsum_load   (ipsum_load),
    .mac_valid    (mac_valid),
    .if_addr      (if_addr),
    .w_addr       (w_addr),
    .psum_capture (psum_capture),
    .out_pix      (out_pix),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: md 0=idle 1=run 2=wait 3=done;
  // pos within a pixel: 0 load, 1..K mac, K+1 drain.
  int       md, pos, mpix, mcred, mk, ml, ms, mib, mwb;
  bit       merr;
  logic [AW-1:0] mifa, mwa;
  int       cyc;

  logic          tr_pe   [TRN];
  logic          tr_ld   [TRN];
  logic          tr_cap  [TRN];
  logic          tr_done [TRN];
  logic          tr_err  [TRN];
  logic          tr_busy [TRN];
  logic [AW-1:0] tr_ifa  [TRN];
  logic [AW-1:0] tr_wa   [TRN];
  logic [PW-1:0] tr_op   [TRN];

  task automatic model_reset();
    md    = 0;
    pos   = 0;
    mpix  = 0;
    mcred = CR;
    merr  = 0;
    mifa  = '0;
    mwa   = '0;
  endtask

  // One clock: check outputs mid-cycle, advance model, land at posedge+1.
  task automatic tick();
    bit e_pe, e_ld, e_mv, e_cap;
    int e_op, nc;
    @(negedge clk);
    e_pe  = (md == 1);
    e_ld  = e_pe && pos == 0;
    e_mv  = e_pe && pos >= 1 && pos <= mk;
    e_cap = e_pe && pos == mk + 1;
    if (e_mv) begin
      mifa = AW'((mib + mpix * ms + pos - 1) % 4096);
      mwa  = AW'((mwb + pos - 1) % 4096);
    end
    e_op = e_cap ? mpix : 0;
    chk("pe_en", 32'(pe_en), 32'(e_pe));
    chk("ipsum_load", 32'(ipsum_load), 32'(e_ld));
    chk("mac_valid", 32'(mac_valid), 32'(e_mv));
    chk("psum_capture", 32'(psum_capture), 32'(e_cap));
    chk("out_pix", 32'(out_pix), 32'(e_op));
    chk("if_addr", 32'(if_addr), 32'(mifa));
    chk("w_addr", 32'(w_addr), 32'(mwa));
    chk("busy", 32'(busy), 32'(md != 0));
    chk("done", 32'(done), 32'(md == 3));
    chk("cfg_err", 32'(cfg_err), 32'(md == 3 && merr));
    if (cyc < TRN) begin
      tr_pe[cyc]   = pe_en;
      tr_ld[cyc]   = ipsum_load;
      tr_cap[cyc]  = psum_capture;
      tr_done[cyc] = done;
      tr_err[cyc]  = cfg_err;
      tr_busy[cyc] = busy;
      tr_ifa[cyc]  = if_addr;
      tr_wa[cyc]   = w_addr;
      tr_op[cyc]   = out_pix;
    end
    nc = mcred;
    if (e_cap && !credit_return) nc = mcred - 1;
    else if (!e_cap && credit_return && mcred < CR) nc = mcred + 1;
    case (md)
      0: if (start) begin
        if (kernel_size == 0 || num_pix == 0) begin
          md   = 3;
          merr = 1;
        end else begin
          merr = 0;
          mk   = int'(kernel_size);
          ml   = int'(num_pix);
          ms   = int'(stride);
          mib  = int'(if_base);
          mwb  = int'(w_base);
          mpix = 0;
          pos  = 0;
          md   = (nc > 0) ? 1 : 2;
        end
      end
      1: if (e_cap) begin
        if (mpix == ml - 1) begin
          md = 3;
        end else begin
          mpix++;
          pos = 0;
          md  = (nc > 0) ? 1 : 2;
        end
      end else begin
        pos++;
      end
      2: if (nc > 0) begin
        md  = 1;
        pos = 0;
      end
      default: md = 0;
    endcase
    mcred = nc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit cr);
    start         = 1'b0;
    credit_return = cr;
    repeat (n) tick();
    credit_return = 1'b0;
  endtask

  // rmode 0: random returns; 1: return at crs, crs+crp, ...;
  // 2: return exactly on every drain.
  task automatic job(input int k, input int l, input int s,
                     input int ib, input int wb,
                     input int rmode, input int crs, input int crp);
    kernel_size   = 8'(k);
    num_pix       = PW'(l);
    stride        = 4'(s);
    if_base       = AW'(ib);
    w_base        = AW'(wb);
    start         = 1'b1;
    credit_return = 1'b0;
    cyc           = 0;
    tick();
    while (md != 0 && cyc < TRN - 2) begin
      kernel_size = 8'($urandom);
      num_pix     = PW'($urandom);
      stride      = 4'($urandom);
      if_base     = AW'($urandom);
      w_base      = AW'($urandom);
      start       = (cyc == 3) || ($urandom % 6 == 0);
      case (rmode)
        0:       credit_return = ($urandom % 3 == 0);
        1:       credit_return = (cyc >= crs)
                                 && ((cyc - crs) % crp == 0);
        default: credit_return = (md == 1 && pos == mk + 1);
      endcase
      tick();
    end
    start         = 1'b0;
    credit_return = 1'b0;
    tick();
    chk("job_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rstn          = 1'b0;
    start         = 1'b0;
    kernel_size   = '0;
    num_pix       = '0;
    stride        = '0;
    if_base       = '0;
    w_base        = '0;
    credit_return = 1'b0;
    cyc           = 0;
    mk            = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pe_en", 32'(pe_en), 32'd0);
    chk("rst_if_addr", 32'(if_addr), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    idle(2, 1'b0);

    // Returns at full credit saturate; 4 pixels then WAIT.
    idle(3, 1'b1);
    job(1, 5, 3, 'h100, 'h20, 1, 20, 10);
    chk("sat_cap12", 32'(tr_cap[12]), 32'd1);
    chk("sat_wait13", 32'(tr_pe[13]), 32'd0);
    chk("wait_pe20", 32'(tr_pe[20]), 32'd0);
    chk("wait_load21", 32'(tr_ld[21]), 32'd1);
    chk("wait_cap23", 32'(tr_cap[23]), 32'd1);
    chk("wait_pix23", 32'(tr_op[23]), 32'd4);
    chk("wait_done24", 32'(tr_done[24]), 32'd1);

    // Credit 1, return coincides with every drain: no WAIT.
    idle(1, 1'b1);
    job(2, 3, 1, 'h40, 'h80, 2, 0, 1);
    chk("sim_load5", 32'(tr_ld[5]), 32'd1);
    chk("sim_load9", 32'(tr_ld[9]), 32'd1);
    chk("sim_cap12", 32'(tr_cap[12]), 32'd1);
    chk("sim_done13", 32'(tr_done[13]), 32'd1);

    // Basic job K=3 L=2 with full credit.
    idle(4, 1'b1);
    job(3, 2, 1, 'h010, 'h000, 1, 1000, 1);
    chk("t1_load1", 32'(tr_ld[1]), 32'd1);
    chk("t1_ifa2", 32'(tr_ifa[2]), 32'h010);
    chk("t1_ifa3", 32'(tr_ifa[3]), 32'h011);
    chk("t1_ifa4", 32'(tr_ifa[4]), 32'h012);
    chk("t1_wa4", 32'(tr_wa[4]), 32'h002);
    chk("t1_cap5", 32'(tr_cap[5]), 32'd1);
    chk("t1_load6", 32'(tr_ld[6]), 32'd1);
    chk("t1_ifa7", 32'(tr_ifa[7]), 32'h011);
    chk("t1_ifa9", 32'(tr_ifa[9]), 32'h013);
    chk("t1_pix10", 32'(tr_op[10]), 32'd1);
    chk("t1_done11", 32'(tr_done[11]), 32'd1);
    chk("t1_busy12", 32'(tr_busy[12]), 32'd0);

    // Address wrap-around.
    job(2, 2, 2, 'hFFE, 'hFFF, 1, 1000, 1);
    chk("wrap_ifa6", 32'(tr_ifa[6]), 32'h000);
    chk("wrap_ifa7", 32'(tr_ifa[7]), 32'h001);
    chk("wrap_wa7", 32'(tr_wa[7]), 32'h000);

    // Bad configurations.
    job(0, 3, 1, 0, 0, 0, 0, 1);
    chk("k0_done1", 32'(tr_done[1]), 32'd1);
    chk("k0_err1", 32'(tr_err[1]), 32'd1);
    chk("k0_pe1", 32'(tr_pe[1]), 32'd0);
    chk("k0_busy2", 32'(tr_busy[2]), 32'd0);
    job(4, 0, 1, 0, 0, 0, 0, 1);
    chk("l0_done1", 32'(tr_done[1]), 32'd1);
    chk("l0_err1", 32'(tr_err[1]), 32'd1);
    chk("l0_pe0", 32'(tr_pe[0]), 32'd0);

    // Reset mid-MAC aborts at once, then a normal job.
    idle(4, 1'b1);
    kernel_size = 8'd5;
    num_pix     = PW'(3);
    stride      = 4'd1;
    if_base     = AW'('h300);
    w_base      = AW'('h10);
    start       = 1'b1;
    cyc         = 0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_mac", 32'(mac_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("ar_pe_en", 32'(pe_en), 32'd0);
    chk("ar_mac", 32'(mac_valid), 32'd0);
    chk("ar_if_addr", 32'(if_addr), 32'd0);
    chk("ar_w_addr", 32'(w_addr), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(4, 1'b0);
    job(2, 2, 3, 'h200, 'h30, 0, 0, 1);

    // Randomized jobs.
    for (int j = 0; j < 60; j++) begin
      int k, l;
      k = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 6));
      l = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 5));
      job(k, l, int'($urandom % 16), int'($urandom % 4096),
          int'($urandom % 4096), 0, 0, 1);
      idle(int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
